// File: rtl/dac_sample_fifo.sv
// Elastic 16->8 bit sample buffer between the speech filter and the PWM DAC.
// Optional build macro UNDERRUN_HOLD_EN: repeat the last code instead of muting on underrun.
module dac_sample_fifo #(
  parameter int unsigned DEPTH_LOG2  = 4,
  parameter int unsigned PRIME_LEVEL = 8
) (
  input  logic                  clk,
  input  logic                  rst_an,
  input  logic [15:0]           sample_in,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic [7:0]            dout,
  input  logic                  dout_ack,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  underrun,
  input  logic                  clr_underrun
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   DepthLvl = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   PrimeLvl = (DEPTH_LOG2 + 1)'(PRIME_LEVEL);
  localparam logic [DEPTH_LOG2:0]   LvlOne   = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PtrOne   = {{(DEPTH_LOG2 - 1){1'b0}}, 1'b1};

  typedef enum logic {StPrime, StRun} state_e;

  state_e                state_q;
  logic [7:0]            mem [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   level_q;
  logic [7:0]            dout_q;
  logic                  underrun_q;
  logic                  ack_en_q;

  logic [8:0] round_sum;
  logic [7:0] code;
  logic [7:0] fill;
  logic       ack, push, pop;
  logic       unused_lsbs;

  // Sign-extended sum: bits 8 and 7 only disagree on positive overflow.
  assign round_sum   = {sample_in[15], sample_in[15:8]} + {8'h00, sample_in[7]};
  assign code        = (round_sum[8] != round_sum[7]) ? 8'h7F : round_sum[7:0];
  assign unused_lsbs = ^sample_in[6:0];

`ifdef UNDERRUN_HOLD_EN
  assign fill = dout_q;
`else
  assign fill = 8'h00;
`endif

  assign sample_ready = (level_q < DepthLvl);
  assign ack          = dout_ack && ack_en_q;
  assign push         = sample_valid && sample_ready;
  assign pop          = ack && (state_q == StRun) && (level_q != '0);

  assign dout     = dout_q;
  assign level    = level_q;
  assign underrun = underrun_q;

  // Storage is not reset; contents are discarded through the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= code;
  end

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      state_q    <= StPrime;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      dout_q     <= 8'h00;
      underrun_q <= 1'b0;
      ack_en_q   <= 1'b0;
    end else begin
      ack_en_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      if (push && !pop)      level_q <= level_q + LvlOne;
      else if (pop && !push) level_q <= level_q - LvlOne;
      if (clr_underrun) underrun_q <= 1'b0;
      // A new underrun below overrides the clear above.
      case (state_q)
        StPrime: begin
          if (ack) dout_q <= fill;
          if (level_q >= PrimeLvl) state_q <= StRun;
        end
        StRun: begin
          if (ack) begin
            if (pop) begin
              dout_q <= mem[rd_ptr_q];
            end else begin
              dout_q     <= fill;
              underrun_q <= 1'b1;
              state_q    <= StPrime;
            end
          end
        end
        default: state_q <= StPrime;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_sample_fifo.sv
// Directed table-driven bench for dac_sample_fifo, plus priming, full, underrun and reset sequences.
module tb_dac_sample_fifo;

  logic        clk = 1'b0;
  logic        rst_an;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic [7:0]  dout;
  logic        dout_ack;
  logic [4:0]  level;
  logic        underrun;
  logic        clr_underrun;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef UNDERRUN_HOLD_EN
  localparam logic [7:0] TblFill  = 8'h04;
  localparam logic [7:0] FullFill = 8'h10;
`else
  localparam logic [7:0] TblFill  = 8'h00;
  localparam logic [7:0] FullFill = 8'h00;
`endif

  dac_sample_fifo #(.DEPTH_LOG2(4), .PRIME_LEVEL(8)) dut (
    .clk          (clk),
    .rst_an       (rst_an),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .dout         (dout),
    .dout_ack     (dout_ack),
    .level        (level),
    .underrun     (underrun),
    .clr_underrun (clr_underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sv;
    logic [15:0] sin;
    logic        ack;
    logic        clr;
    logic [7:0]  e_dout;
    logic [4:0]  e_lvl;
    logic        e_rdy;
    logic        e_und;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [7:0] e_dout, input logic [4:0] e_lvl,
                           input logic e_rdy, input logic e_und);
    check({tag, ".dout"}, {8'h00, dout}, {8'h00, e_dout});
    check({tag, ".level"}, {11'h0, level}, {11'h0, e_lvl});
    check({tag, ".ready"}, {15'h0, sample_ready}, {15'h0, e_rdy});
    check({tag, ".underrun"}, {15'h0, underrun}, {15'h0, e_und});
  endtask

  task automatic add(input logic sv, input logic [15:0] sin, input logic ack, input logic clr,
                     input logic [7:0] e_dout, input logic [4:0] e_lvl, input logic e_und);
    vec_t v;
    v.sv = sv; v.sin = sin; v.ack = ack; v.clr = clr;
    v.e_dout = e_dout; v.e_lvl = e_lvl; v.e_rdy = (e_lvl < 5'd16); v.e_und = e_und;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    rst_an = 1'b0;
    #2;
    rst_an = 1'b1;
  endtask

  task automatic push(input logic [15:0] s);
    sample_valid = 1'b1;
    sample_in    = s;
    tick();
    sample_valid = 1'b0;
  endtask

  initial begin
    rst_an = 1'b0; sample_in = '0; sample_valid = 1'b0; dout_ack = 1'b0; clr_underrun = 1'b0;
    #1;
    check_all("reset", 8'h00, 5'd0, 1'b1, 1'b0);
    #12;
    rst_an = 1'b1;

    // Conversion, priming, concurrent push/pop at level 8, drain, underrun, clear.
    add(0, 16'h0000, 0, 0, 8'h00, 5'd0, 0);
    add(1, 16'h1234, 0, 0, 8'h00, 5'd1, 0);
    add(1, 16'h1280, 0, 0, 8'h00, 5'd2, 0);
    add(1, 16'h7F80, 0, 0, 8'h00, 5'd3, 0);
    add(1, 16'h8000, 0, 0, 8'h00, 5'd4, 0);
    add(1, 16'hFF80, 0, 0, 8'h00, 5'd5, 0);
    add(1, 16'h0100, 0, 0, 8'h00, 5'd6, 0);
    add(1, 16'h0200, 0, 0, 8'h00, 5'd7, 0);
    add(1, 16'h0300, 0, 0, 8'h00, 5'd8, 0);
    add(0, 16'h0000, 0, 0, 8'h00, 5'd8, 0);
    add(1, 16'h0400, 1, 0, 8'h12, 5'd8, 0);
    add(0, 16'h0000, 1, 0, 8'h13, 5'd7, 0);
    add(0, 16'h0000, 1, 0, 8'h7F, 5'd6, 0);
    add(0, 16'h0000, 1, 0, 8'h80, 5'd5, 0);
    add(0, 16'h0000, 1, 0, 8'h00, 5'd4, 0);
    add(0, 16'h0000, 1, 0, 8'h01, 5'd3, 0);
    add(0, 16'h0000, 1, 0, 8'h02, 5'd2, 0);
    add(0, 16'h0000, 1, 0, 8'h03, 5'd1, 0);
    add(0, 16'h0000, 1, 0, 8'h04, 5'd0, 0);
    add(0, 16'h0000, 1, 0, TblFill, 5'd0, 1);
    add(0, 16'h0000, 0, 1, TblFill, 5'd0, 0);
    add(0, 16'h0000, 1, 0, TblFill, 5'd0, 0);

    foreach (vecs[i]) begin
      sample_valid = vecs[i].sv; sample_in = vecs[i].sin;
      dout_ack = vecs[i].ack; clr_underrun = vecs[i].clr;
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].e_dout, vecs[i].e_lvl, vecs[i].e_rdy,
                vecs[i].e_und);
    end
    sample_valid = 1'b0; dout_ack = 1'b0; clr_underrun = 1'b0;

    // Priming: 7 samples are not enough to release data.
    do_reset();
    tick();
    for (int i = 1; i <= 7; i++) push(16'(i << 8));
    dout_ack = 1'b1; tick(); dout_ack = 1'b0;
    check_all("prime7", 8'h00, 5'd7, 1'b1, 1'b0);
    push(16'h0800);
    tick();
    dout_ack = 1'b1; tick(); dout_ack = 1'b0;
    check_all("prime8", 8'h01, 5'd7, 1'b1, 1'b0);

    // Full: 17th push is dropped, then 16 samples drain in order.
    do_reset();
    tick();
    sample_valid = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      sample_in = 16'(i << 8);
      tick();
    end
    sample_valid = 1'b0;
    check_all("full", 8'h00, 5'd16, 1'b0, 1'b0);
    dout_ack = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check($sformatf("drain%0d", i), {8'h00, dout}, 16'(i));
    end
    dout_ack = 1'b0;
    check("drained.level", {11'h0, level}, 16'd0);

    // Push + ack at level 0 in RUN with clear: push kept, underrun set wins.
    sample_valid = 1'b1; sample_in = 16'h0500; dout_ack = 1'b1; clr_underrun = 1'b1;
    tick();
    sample_valid = 1'b0; dout_ack = 1'b0; clr_underrun = 1'b0;
    check_all("urun_clr", FullFill, 5'd1, 1'b1, 1'b1);
    clr_underrun = 1'b1; tick(); clr_underrun = 1'b0;
    check_all("clr", FullFill, 5'd1, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle at level 5.
    for (int i = 0; i < 4; i++) push(16'h0600);
    check("pre_rst.level", {11'h0, level}, 16'd5);
    #3;
    rst_an = 1'b0;
    #1;
    check_all("async_rst", 8'h00, 5'd0, 1'b1, 1'b0);
    #2;
    rst_an = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
